// File: rtl/uart_rx_sampler_pkg.sv
// uart_rx_sampler shared types
// receiver states, parity encodings, voter
package uart_rx_sampler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_bit_sync.sv
// bit_sync: multi-flop synchroniser
// reset value selectable so idle lines stay idle
module bit_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // shift the raw input through the flop chain
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= STAGES'({sync_q, d_i});
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampled UART receive front-end
// start detect, mid-bit majority vote, parity/stop check
module uart_rx_sampler
  import uart_rx_sampler_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OSR         = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 rx_i,
  input  logic                 parity_en_i,
  input  logic                 parity_type_i,
  input  logic                 data_ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 parity_error_o,
  output logic                 frame_error_o,
  output logic                 overrun_o
);

  localparam int unsigned SW = $clog2(OSR);
  localparam int unsigned BW =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] SMP_ONE  = SW'(1);
  localparam logic [SW-1:0] SMP_LO   = SW'(OSR/2 - 1);
  localparam logic [SW-1:0] SMP_MID  = SW'(OSR/2);
  localparam logic [SW-1:0] SMP_HI   = SW'(OSR/2 + 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_e state_q, state_d;

  logic [SW-1:0]        smp_q, smp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           vote_q, vote_d;
  logic                 par_q, par_d;
  logic                 pen_q, pen_d;
  logic                 ptype_q, ptype_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic rx_s;
  logic maj;
  logic decide;
  logic wrap;

  bit_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  assign maj    = maj3(vote_q[1], vote_q[0], rx_s);
  assign decide = (smp_q == SMP_HI);
  assign wrap   = (smp_q == SMP_LAST);

  // next-state, sampling and frame result logic
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    vote_d  = vote_q;
    par_d   = par_q;
    pen_d   = pen_q;
    ptype_d = ptype_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (state_q != IDLE) begin
      smp_d = wrap ? '0 : smp_q + SMP_ONE;
      if (smp_q == SMP_LO || smp_q == SMP_MID) begin
        vote_d = {vote_q[0], rx_s};
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          smp_d   = SMP_ONE;
          pen_d   = parity_en_i;
          ptype_d = parity_type_i;
          state_d = START;
        end
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
        end else if (wrap) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
        end
        if (wrap) begin
          if (bit_q == BIT_LAST) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (decide) begin
          par_d = maj;
        end
        if (wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (maj) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = pen_q &
              ((^shift_q ^ par_q) != ptype_q);
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vote_q  <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vote_q  <= vote_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      ptype_q <= ptype_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign parity_error_o = perr_q;
  assign frame_error_o  = ferr_q;
  assign overrun_o      = valid_q & ~data_ready_i;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: randomized frame-level bench
// events compared against a frame timing/content model
module tb_uart_rx_sampler;
  import uart_rx_sampler_pkg::*;

  localparam int DB   = 8;
  localparam int OSR  = 8;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  f;
    logic [7:0]  d;
  } ev_t;

  logic          clk;
  logic          arst_ni;
  logic          rx_i;
  logic          parity_en_i;
  logic          parity_type_i;
  logic          data_ready_i;
  logic [DB-1:0] data_o;
  logic          data_valid_o;
  logic          parity_error_o;
  logic          frame_error_o;
  logic          overrun_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [7:0] last_data = '0;
  ev_t  got_q[$];
  ev_t  exp_q[$];
  ev_t  mon_ev;

  uart_rx_sampler #(
    .DATA_BITS  (DB),
    .OSR        (OSR),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i         (clk),
    .arst_ni       (arst_ni),
    .rx_i          (rx_i),
    .parity_en_i   (parity_en_i),
    .parity_type_i (parity_type_i),
    .data_ready_i  (data_ready_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .parity_error_o(parity_error_o),
    .frame_error_o (frame_error_o),
    .overrun_o     (overrun_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arst_ni && (data_valid_o | parity_error_o |
                    frame_error_o | overrun_o)) begin
      mon_ev.cyc = 32'(cyc);
      mon_ev.f = {data_valid_o, parity_error_o,
                  frame_error_o, overrun_o};
      mon_ev.d = data_o;
      got_q.push_back(mon_ev);
    end
  end

  task automatic expect_frame(input int c, input logic [7:0] d,
                              input logic pen, input logic ptype,
                              input logic parbit, input logic stopbit,
                              input logic rdy);
    ev_t e;
    int  lat;
    int  ones;
    lat = SYNC + (1 + DB + int'(pen)) * OSR + OSR / 2 + 2;
    e.cyc = 32'(c + lat);
    if (stopbit) begin
      ones = $countones(d) + int'(parbit);
      e.d = d;
      e.f = {1'b1, pen && ((ones % 2) != int'(ptype)), 1'b0, !rdy};
      last_data = d;
    end else begin
      e.d = last_data;
      e.f = 4'b0010;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen,
                            input logic ptype, input logic parbit,
                            input logic stopbit, input logic rdy,
                            input int glitch_bit);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[i+1] = d[i];
    if (pen) begin
      bits[9] = parbit;
      bits[10] = stopbit;
      nb = 11;
    end else begin
      bits[9] = stopbit;
      nb = 10;
    end
    parity_en_i = pen;
    parity_type_i = ptype;
    expect_frame(cyc, d, pen, ptype, parbit, stopbit, rdy);
    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s < OSR; s++) begin
        if (b == glitch_bit && s >= 1 && s <= 3) rx_i = ~bits[b];
        else rx_i = bits[b];
        if (b == 1 && s == 0) begin
          data_ready_i = rdy;
          parity_en_i = 1'($urandom);
          parity_type_i = 1'($urandom);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    rx_i = 1'b1;
    data_ready_i = 1'b1;
    parity_en_i = 1'b0;
    parity_type_i = PARITY_EVEN;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_o !== 8'h00) $display("FAIL rst_data got %h want 00", data_o);
    else n_pass++;
    n_checks++;
    if (data_valid_o !== 1'b0) $display("FAIL rst_valid got %b want 0", data_valid_o);
    else n_pass++;
    n_checks++;
    if ({parity_error_o, frame_error_o, overrun_o} !== 3'b000)
      $display("FAIL rst_flags got %b want 000",
               {parity_error_o, frame_error_o, overrun_o});
    else n_pass++;
    arst_ni = 1'b1;
    clear_q();
    idle(20);
    n_checks++;
    if (got_q.size() != 0) $display("FAIL rst_quiet got %0d events want 0", got_q.size());
    else n_pass++;
  endtask

  task automatic test_basic();
    clear_q();
    send_frame(8'hA5, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1, -1);
    idle(16);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL basic_ev%0d got cyc=%0d f=%b d=%h want cyc=%0d f=%b d=%h", i,
                 got_q[i].cyc, got_q[i].f, got_q[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_parity();
    clear_q();
    send_frame(8'h07, 1'b1, PARITY_EVEN, 1'b1, 1'b1, 1'b1, -1);
    idle(4);
    send_frame(8'h07, 1'b1, PARITY_EVEN, 1'b0, 1'b1, 1'b1, -1);
    idle(4);
    send_frame(8'hC3, 1'b1, PARITY_ODD, 1'b1, 1'b1, 1'b1, -1);
    idle(16);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL parity_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL parity_ev%0d got cyc=%0d f=%b d=%h want cyc=%0d f=%b d=%h", i,
                 got_q[i].cyc, got_q[i].f, got_q[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_break();
    clear_q();
    send_frame(8'h55, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 1'b1, -1);
    rx_i = 1'b0;
    repeat (40) @(negedge clk);
    idle(16);
    send_frame(8'h3C, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1, -1);
    idle(16);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL break_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL break_ev%0d got cyc=%0d f=%b d=%h want cyc=%0d f=%b d=%h", i,
                 got_q[i].cyc, got_q[i].f, got_q[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    clear_q();
    rx_i = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    n_checks++;
    if (got_q.size() != 0)
      $display("FAIL glitch_quiet got %0d events want 0", got_q.size());
    else n_pass++;
    clear_q();
    send_frame(8'h00, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1, 4);
    idle(16);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL glitch_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL glitch_ev%0d got cyc=%0d f=%b d=%h want cyc=%0d f=%b d=%h", i,
                 got_q[i].cyc, got_q[i].f, got_q[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h12, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h34, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'h56, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1, -1);
    idle(16);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL b2b_ev%0d got cyc=%0d f=%b d=%h want cyc=%0d f=%b d=%h", i,
                 got_q[i].cyc, got_q[i].f, got_q[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    parity_en_i = 1'b0;
    rx_i = 1'b0;
    repeat (OSR) @(negedge clk);
    rx_i = 1'b1;
    repeat (4 * OSR + 3) @(negedge clk);
    arst_ni = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_o, data_valid_o} !== 9'h000)
      $display("FAIL midrst_out got d=%h v=%b want d=00 v=0", data_o, data_valid_o);
    else n_pass++;
    @(negedge clk);
    arst_ni = 1'b1;
    last_data = 8'h00;
    idle(120);
    n_checks++;
    if (got_q.size() != 0)
      $display("FAIL midrst_quiet got %0d events want 0", got_q.size());
    else n_pass++;
    n_checks++;
    if (data_o !== 8'h00) $display("FAIL midrst_data got %h want 00", data_o);
    else n_pass++;
    send_frame(8'h81, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 1'b1, -1);
    idle(16);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL midrst_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL midrst_ev%0d got cyc=%0d f=%b d=%h want cyc=%0d f=%b d=%h", i,
                 got_q[i].cyc, got_q[i].f, got_q[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int k = 0; k < 16; k++) begin
      idle($urandom_range(0, 3));
      send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b1, $urandom_range(0, 3) != 0, -1);
    end
    idle(16);
    data_ready_i = 1'b1;
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL rand_ev%0d got cyc=%0d f=%b d=%h want cyc=%0d f=%b d=%h", i,
                 got_q[i].cyc, got_q[i].f, got_q[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      else n_pass++;
    end
  endtask

  initial begin
    arst_ni = 1'b0;
    rx_i = 1'b1;
    data_ready_i = 1'b1;
    parity_en_i = 1'b0;
    parity_type_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
